cache_req_driver: RTL and testbench

CPU-side request initiator and self-checker for the set-associative data cache's word interface. On `start` it writes a generated pattern of words through the cache, reads every word back, and compares the result against the same pattern. It reports pass/fail, error count, miss count and cycle count. It sits where the CPU would sit: it drives `addr`/`rd_req`/`wr_req`/`wr_data`, and it consumes `miss`/`rd_data` (miss is combinational, rd_data is registered).

---
 rtl/cache_req_driver_if.sv | 21 ++
 rtl/cache_req_driver.sv | 205 ++++++++++++++++++++
 tb/tb_cache_req_driver.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_driver_if.sv
// Word-level request bus between a CPU-side initiator and the data cache.
// Latency: miss is combinational on the request; rd_data arrives one cycle after the accepting edge.
// Backpressure: miss=1 stalls the current access; the initiator holds addr/wr_data/request stable.
interface cache_req_driver_if;
  logic [31:0] addr;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        miss;
  logic [31:0] rd_data;

  modport master (
    output addr, rd_req, wr_req, wr_data,
    input  miss, rd_data
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_data,
    output miss, rd_data
  );
endinterface

// File: rtl/cache_req_driver.sv
// Writes a seeded word pattern through the cache, reads it back and checks it, with result counters.
// Latency: 2 cycles per accepted access (REQ + GAP/CHK), 4N + stall cycles per run; N==0 takes 1 busy cycle.
// Backpressure: miss holds the current request stable; TIMEOUT consecutive stall cycles abort the run.
module cache_req_driver #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [31:0]       i_cfg_base,
  input  logic [31:0]       i_cfg_stride,
  input  logic [CNT_W-1:0]  i_cfg_count,
  input  logic [31:0]       i_cfg_seed,
  cache_req_driver_if.master cache,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_first_err_idx,
  output logic [31:0]       o_miss_cnt,
  output logic [31:0]       o_cycle_cnt
);

  localparam logic [31:0] LP_DATA_STEP = 32'h0101_0101;
  localparam logic [31:0] LP_STALL_MAX = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_CHK, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_base;
  logic [31:0]      r_stride;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_seed;
  logic [31:0]      r_idx;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [31:0]      r_wr_data;
  logic [31:0]      r_stall;
  logic             r_timeout;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [31:0]      r_miss_cnt;
  logic [31:0]      r_cycle_cnt;

  logic w_busy;
  logic w_wr_req;
  logic w_rd_req;
  logic w_last;
  logic w_empty;
  logic w_stall_last;

  assign w_last       = (r_idx == (32'(r_count) - 32'd1));
  assign w_empty      = (r_count == '0);
  assign w_stall_last = (r_stall == LP_STALL_MAX);

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and request decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_wr_req    = 1'b0;
    w_rd_req    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        // N==0 still spends one busy cycle in the gap state before finishing.
        if (i_start) w_state_nxt = w_empty_cfg() ? S_WR_GAP : S_WR_REQ;
      end
      S_WR_REQ: begin
        w_busy   = 1'b1;
        w_wr_req = 1'b1;
        if (!cache.miss)       w_state_nxt = S_WR_GAP;
        else if (w_stall_last) w_state_nxt = S_DONE;
      end
      S_WR_GAP: begin
        w_busy = 1'b1;
        if (w_empty)     w_state_nxt = S_DONE;
        else if (w_last) w_state_nxt = S_RD_REQ;
        else             w_state_nxt = S_WR_REQ;
      end
      S_RD_REQ: begin
        w_busy   = 1'b1;
        w_rd_req = 1'b1;
        if (!cache.miss)       w_state_nxt = S_RD_CHK;
        else if (w_stall_last) w_state_nxt = S_DONE;
      end
      S_RD_CHK: begin
        w_busy = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_RD_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  function automatic logic w_empty_cfg();
    return (i_cfg_count == '0);
  endfunction

  // Datapath: config latch, element address/data walk, stall and result counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base          <= '0;
      r_stride        <= '0;
      r_count         <= '0;
      r_seed          <= '0;
      r_idx           <= '0;
      r_addr          <= '0;
      r_data          <= '0;
      r_wr_data       <= '0;
      r_stall         <= '0;
      r_timeout       <= 1'b0;
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_miss_cnt      <= '0;
      r_cycle_cnt     <= '0;
    end else begin
      if (w_busy) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_base          <= i_cfg_base;
            r_stride        <= i_cfg_stride;
            r_count         <= i_cfg_count;
            r_seed          <= i_cfg_seed;
            r_idx           <= '0;
            r_addr          <= i_cfg_base;
            r_data          <= i_cfg_seed;
            r_wr_data       <= i_cfg_seed;
            r_stall         <= '0;
            r_timeout       <= 1'b0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_miss_cnt      <= '0;
            r_cycle_cnt     <= '0;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (cache.miss) begin
            // Only the first request cycle of an access counts as a miss.
            if (r_stall == '0) r_miss_cnt <= r_miss_cnt + 32'd1;
            if (w_stall_last) begin
              r_timeout <= 1'b1;
              r_stall   <= '0;
            end else begin
              r_stall <= r_stall + 32'd1;
            end
          end else begin
            r_stall <= '0;
          end
        end
        S_WR_GAP: begin
          if (!w_empty) begin
            if (w_last) begin
              r_idx  <= '0;
              r_addr <= r_base;
              r_data <= r_seed;
            end else begin
              r_idx     <= r_idx + 32'd1;
              r_addr    <= r_addr + r_stride;
              r_data    <= r_data + LP_DATA_STEP;
              r_wr_data <= r_data + LP_DATA_STEP;
            end
          end
        end
        S_RD_CHK: begin
          if (cache.rd_data != r_data) begin
            if (r_err_cnt == '0)  r_first_err_idx <= r_idx[CNT_W-1:0];
            if (r_err_cnt != '1)  r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          if (!w_last) begin
            r_idx  <= r_idx + 32'd1;
            r_addr <= r_addr + r_stride;
            r_data <= r_data + LP_DATA_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign cache.addr    = r_addr;
  assign cache.wr_data = r_wr_data;
  assign cache.wr_req  = w_wr_req;
  assign cache.rd_req  = w_rd_req;

  assign o_busy          = w_busy;
  assign o_done          = (r_state == S_DONE);
  assign o_pass          = (r_state == S_DONE) && (r_err_cnt == '0) && !r_timeout;
  assign o_timeout       = r_timeout;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err_idx;
  assign o_miss_cnt      = r_miss_cnt;
  assign o_cycle_cnt     = r_cycle_cnt;

endmodule

// File: tb/tb_cache_req_driver.sv
// Directed bench for cache_req_driver with a word memory and programmable stall model.
// Latency: outputs sampled on the falling edge, mid-cycle.
// Backpressure: miss comes from a tie-high switch or a per-address write stall of fixed length.
module tb_cache_req_driver;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      cfg_base;
  logic [31:0]      cfg_stride;
  logic [CNT_W-1:0] cfg_count;
  logic [31:0]      cfg_seed;
  logic             busy, done, pass, tmo;
  logic [CNT_W-1:0] err_cnt, first_err_idx;
  logic [31:0]      miss_cnt, cycle_cnt;

  cache_req_driver_if bus();

  cache_req_driver #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_start(start),
    .i_cfg_base(cfg_base), .i_cfg_stride(cfg_stride),
    .i_cfg_count(cfg_count), .i_cfg_seed(cfg_seed),
    .cache(bus),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(tmo),
    .o_err_cnt(err_cnt), .o_first_err_idx(first_err_idx),
    .o_miss_cnt(miss_cnt), .o_cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Memory / stall model standing in for the cache.
  logic        miss_tie;
  logic        corrupt;
  logic [31:0] stall_addr;
  int          stall_len;
  int          stall_used;
  logic [31:0] mem [0:63];

  assign bus.miss = miss_tie |
                    (bus.wr_req && (bus.addr == stall_addr) && (stall_used < stall_len));

  always @(posedge clk) begin
    if (start) stall_used <= 0;
    else if (bus.wr_req && (bus.addr == stall_addr) && (stall_used < stall_len))
      stall_used <= stall_used + 1;
    if (bus.wr_req && !bus.miss) mem[bus.addr[7:2]] <= bus.wr_data;
    if (bus.rd_req && !bus.miss)
      bus.rd_data <= mem[bus.addr[7:2]] ^ {31'd0, (corrupt && (bus.addr == 32'd12))};
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Per-run observations collected while waiting for done.
  logic        req_seen;
  int          req_cycles;
  int          stall_cycles;
  int          stall_bad;
  logic [31:0] wr7_data;
  logic [31:0] exp_stall_data;
  int          run_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [31:0] stride,
                          input logic [CNT_W-1:0] count, input logic [31:0] seed);
    req_seen     = 1'b0;
    req_cycles   = 0;
    stall_cycles = 0;
    stall_bad    = 0;
    wr7_data     = 32'hdead_beef;
    @(negedge clk);
    cfg_base   = base;
    cfg_stride = stride;
    cfg_count  = count;
    cfg_seed   = seed;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run_wait(input int budget);
    run_cycles = 0;
    while (!done && run_cycles < budget) begin
      if (bus.rd_req || bus.wr_req) begin
        req_seen = 1'b1;
        req_cycles++;
      end
      if (bus.wr_req && !bus.miss && bus.addr == 32'd28) wr7_data = bus.wr_data;
      if (bus.wr_req && bus.miss && !miss_tie) begin
        stall_cycles++;
        if (bus.addr !== stall_addr || bus.wr_data !== exp_stall_data) stall_bad++;
      end
      @(negedge clk);
      run_cycles++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_count = '0; cfg_seed = '0;
    miss_tie = 1'b0; corrupt = 1'b0;
    stall_addr = '0; stall_len = 0; exp_stall_data = '0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_addr",      bus.addr, 32'd0);
    check("rst_rd_req",    32'(bus.rd_req), 32'd0);
    check("rst_wr_req",    32'(bus.wr_req), 32'd0);
    check("rst_wr_data",   bus.wr_data, 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_done",      32'(done), 32'd0);
    check("rst_pass",      32'(pass), 32'd0);
    check("rst_timeout",   32'(tmo), 32'd0);
    check("rst_err_cnt",   32'(err_cnt), 32'd0);
    check("rst_first_err", 32'(first_err_idx), 32'd0);
    check("rst_miss_cnt",  miss_cnt, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b0;

    // N==0: one busy cycle, done the next, no requests
    do_start(32'd0, 32'd4, '0, 32'h1000);
    check("n0_busy_t0p1", 32'(busy), 32'd1);
    run_wait(20);
    check("n0_done_delay", 32'(run_cycles), 32'd1);
    check("n0_done",      32'(done), 32'd1);
    check("n0_pass",      32'(pass), 32'd1);
    check("n0_err_cnt",   32'(err_cnt), 32'd0);
    check("n0_miss_cnt",  miss_cnt, 32'd0);
    check("n0_cycle_cnt", cycle_cnt, 32'd1);
    check("n0_no_req",    32'(req_seen), 32'd0);

    // N=8 with a 3-cycle miss on the first write only
    stall_addr = 32'd0; stall_len = 3; exp_stall_data = 32'h0000_1000;
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    run_wait(200);
    check("a_done",      32'(done), 32'd1);
    check("a_pass",      32'(pass), 32'd1);
    check("a_err_cnt",   32'(err_cnt), 32'd0);
    check("a_miss_cnt",  miss_cnt, 32'd1);
    check("a_cycle_cnt", cycle_cnt, 32'd35);
    check("a_wr7_data",  wr7_data, 32'h0707_1707);
    check("a_stalls",    32'(stall_cycles), 32'd3);

    // Bit 0 of element 3 read-back corrupted
    stall_len = 0; corrupt = 1'b1;
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    run_wait(200);
    check("c_done",      32'(done), 32'd1);
    check("c_err_cnt",   32'(err_cnt), 32'd1);
    check("c_first_err", 32'(first_err_idx), 32'd3);
    check("c_pass",      32'(pass), 32'd0);
    check("c_cycle_cnt", cycle_cnt, 32'd32);
    check("c_miss_cnt",  miss_cnt, 32'd0);
    corrupt = 1'b0;

    // 5-cycle stall on write element 2: request held stable
    stall_addr = 32'd8; stall_len = 5; exp_stall_data = 32'h0202_1202;
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    run_wait(200);
    check("s_stalls",    32'(stall_cycles), 32'd5);
    check("s_stable",    32'(stall_bad), 32'd0);
    check("s_miss_cnt",  miss_cnt, 32'd1);
    check("s_cycle_cnt", cycle_cnt, 32'd37);
    check("s_pass",      32'(pass), 32'd1);
    stall_len = 0;

    // Miss tied high: abort after 16 stall cycles
    miss_tie = 1'b1;
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    run_wait(200);
    check("t_done",       32'(done), 32'd1);
    check("t_timeout",    32'(tmo), 32'd1);
    check("t_pass",       32'(pass), 32'd0);
    check("t_req_cycles", 32'(req_cycles), 32'd16);
    check("t_wr_req_low", 32'(bus.wr_req), 32'd0);
    check("t_rd_req_low", 32'(bus.rd_req), 32'd0);
    check("t_cycle_cnt",  cycle_cnt, 32'd16);
    check("t_miss_cnt",   miss_cnt, 32'd1);
    miss_tie = 1'b0;

    // Asynchronous reset in the middle of a read request
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    begin
      int k;
      k = 0;
      while (!bus.rd_req && k < 100) begin
        @(posedge clk); #2;
        k++;
      end
    end
    check("r_rd_seen", 32'(bus.rd_req), 32'd1);
    rst = 1'b1;
    #1;
    check("r_rd_req",    32'(bus.rd_req), 32'd0);
    check("r_wr_req",    32'(bus.wr_req), 32'd0);
    check("r_busy",      32'(busy), 32'd0);
    check("r_done",      32'(done), 32'd0);
    check("r_addr",      bus.addr, 32'd0);
    check("r_wr_data",   bus.wr_data, 32'd0);
    check("r_cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(32'd0, 32'd4, 16'd8, 32'h1000);
    run_wait(200);
    check("r2_done",      32'(done), 32'd1);
    check("r2_pass",      32'(pass), 32'd1);
    check("r2_cycle_cnt", cycle_cnt, 32'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
